// File: rtl/diff_combiner_pkg.sv
// Shared constants for diff_combiner: mode encoding, register offsets, reset defaults.
// Pure definitions; no logic, no latency, no backpressure.
package diff_combiner_pkg;

  typedef enum logic [1:0] {
    MODE_SUB  = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_A    = 2'd2,
    MODE_NEGB = 2'd3
  } mode_e;

  localparam logic [15:0] OFS_MODE   = 16'h0000;
  localparam logic [15:0] OFS_SHIFT  = 16'h0004;
  localparam logic [15:0] OFS_OFFSET = 16'h0008;
  localparam logic [15:0] OFS_HOLD   = 16'h000C;
  localparam logic [15:0] OFS_SATCNT = 16'h0010;

  // Defaults reproduce the legacy (A-B)>>>1 output.
  localparam mode_e      MODE_RST  = MODE_SUB;
  localparam logic [1:0] SHIFT_RST = 2'd1;
  localparam logic       HOLD_RST  = 1'b0;

endpackage

// File: rtl/diff_combiner_if.sv
// Register bus for diff_combiner: single-cycle strobes, ack and rdata one cycle later.
// No backpressure; every strobe is acknowledged.
interface diff_combiner_if;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output addr, wen, ren, wdata, input ack, rdata);
  modport slave  (input addr, wen, ren, wdata, output ack, rdata);
endinterface

// File: rtl/diff_combiner_sat_clamp.sv
// Signed IW-to-OW clamp with clip flag; purely combinational, zero latency.
// No handshake, no backpressure.
module sat_clamp #(
  parameter int IW = 16,
  parameter int OW = 14
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clip
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    dout = din[OW-1:0];
    clip = 1'b0;
    if (din > MAXV) begin
      dout = MAXV[OW-1:0];
      clip = 1'b1;
    end else if (din < MINV) begin
      dout = MINV[OW-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/diff_combiner.sv
// Two-stage combine/shift/offset/clamp pipeline with register bus; out_o 2 cycles after inputs.
// hold freezes both stages; bus never stalls. Optional DIFF_COMBINER_SATCNT_EN adds the saturation counter.
module diff_combiner
  import diff_combiner_pkg::*;
#(
  parameter int          DW    = 14,
  parameter int          CNT_W = 32,
  parameter logic [15:0] BASE  = 16'h0100
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] plus_i,
  input  logic signed [DW-1:0] minus_i,
  output logic signed [DW-1:0] out_o,
  output logic                 sat_o,
  diff_combiner_if.slave       bus
);

  localparam logic [15:0] A_MODE   = BASE + OFS_MODE;
  localparam logic [15:0] A_SHIFT  = BASE + OFS_SHIFT;
  localparam logic [15:0] A_OFFSET = BASE + OFS_OFFSET;
  localparam logic [15:0] A_HOLD   = BASE + OFS_HOLD;
  localparam logic [15:0] A_SATCNT = BASE + OFS_SATCNT;

  mode_e          mode_q;
  logic [1:0]     shift_q;
  logic [DW-1:0]  offset_q;
  logic           hold_q;
  logic [31:0]    satcnt_rd;
  logic [31:0]    rd_val;
  logic           unused_wdata;

  logic signed [DW:0]   a_ext, b_ext, s1_nxt, s1_q, shifted;
  logic [1:0]           s1_shift_q;
  logic [DW-1:0]        s1_off_q;
  logic signed [DW+1:0] sum;
  logic signed [DW-1:0] clamp_out;
  logic                 clamp_clip;

  assign unused_wdata = ^bus.wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= MODE_RST;
      shift_q  <= SHIFT_RST;
      offset_q <= '0;
      hold_q   <= HOLD_RST;
    end else if (bus.wen) begin
      if (bus.addr == A_MODE)   mode_q   <= mode_e'(bus.wdata[1:0]);
      if (bus.addr == A_SHIFT)  shift_q  <= bus.wdata[1:0];
      if (bus.addr == A_OFFSET) offset_q <= bus.wdata[DW-1:0];
      if (bus.addr == A_HOLD)   hold_q   <= bus.wdata[0];
    end
  end

`ifdef DIFF_COMBINER_SATCNT_EN
  logic [CNT_W-1:0] satcnt_q;
  logic             satcnt_clr;

  assign satcnt_clr = bus.wen && (bus.addr == A_SATCNT);

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || satcnt_clr)
      satcnt_q <= '0;
    else if (sat_o && (satcnt_q != '1))
      satcnt_q <= satcnt_q + CNT_W'(1);
  end

  assign satcnt_rd = 32'(satcnt_q);
`else
  assign satcnt_rd = '0;
`endif

  always_comb begin
    rd_val = '0;
    if      (bus.addr == A_MODE)   rd_val = {30'd0, mode_q};
    else if (bus.addr == A_SHIFT)  rd_val = {30'd0, shift_q};
    else if (bus.addr == A_OFFSET) rd_val = 32'(offset_q);
    else if (bus.addr == A_HOLD)   rd_val = {31'd0, hold_q};
    else if (bus.addr == A_SATCNT) rd_val = satcnt_rd;
  end

  // Read data is taken from the pre-edge registers, so a same-cycle write reads the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= bus.wen | bus.ren;
      bus.rdata <= bus.ren ? rd_val : '0;
    end
  end

  always_comb begin
    a_ext = {plus_i[DW-1], plus_i};
    b_ext = {minus_i[DW-1], minus_i};
    case (mode_q)
      MODE_SUB:  s1_nxt = a_ext - b_ext;
      MODE_ADD:  s1_nxt = a_ext + b_ext;
      MODE_A:    s1_nxt = a_ext;
      MODE_NEGB: s1_nxt = -b_ext;
      default:   s1_nxt = '0;
    endcase
  end

  // shift/offset travel with the sample so a config write only affects newer samples.
  assign shifted = s1_q >>> s1_shift_q;
  assign sum     = {shifted[DW], shifted} + {{2{s1_off_q[DW-1]}}, s1_off_q};

  sat_clamp #(.IW(DW+2), .OW(DW)) u_clamp (
    .din  (sum),
    .dout (clamp_out),
    .clip (clamp_clip)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= '0;
      s1_shift_q <= '0;
      s1_off_q   <= '0;
      out_o      <= '0;
      sat_o      <= 1'b0;
    end else if (!hold_q) begin
      s1_q       <= s1_nxt;
      s1_shift_q <= shift_q;
      s1_off_q   <= offset_q;
      out_o      <= clamp_out;
      sat_o      <= clamp_clip;
    end
  end

endmodule
